game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: run/over state machine for the runner game. Tracks the BCD
// score and best score, scroll speed, obstacle spawn pacing and the
// post-game button lockout.
module game_ctrl #(
    parameter int TICKS_PER_POINT = 6,
    parameter int SPEED_INIT      = 1,
    parameter int SPEED_MAX       = 15,
    parameter int GAP_MIN         = 40,
    parameter int OVER_LOCK       = 30
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tick,
    input  logic        btn_jump,
    input  logic        collision,
    output logic        game_status,
    output logic        game_over,
    output logic [3:0]  speed,
    output logic [15:0] score,
    output logic [15:0] hi_score,
    output logic        spawn
);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    localparam logic [15:0] PT_LAST   = 16'(TICKS_PER_POINT - 1);
    localparam logic [3:0]  SPD_INIT  = 4'(SPEED_INIT);
    localparam logic [3:0]  SPD_MAX   = 4'(SPEED_MAX);
    localparam logic [15:0] SCORE_TOP = 16'h9999;

    state_t      state;
    logic        btn_q;
    logic [15:0] lfsr;
    logic [15:0] pcnt;
    logic [15:0] gap;
    logic [15:0] lock;

    logic        press;
    logic        start;
    logic [15:0] gap_load;
    logic [15:0] score_inc;
    logic        carry;

    assign press    = btn_jump & ~btn_q;
    // A new game may begin from IDLE, or from OVER once the lockout expired.
    assign start    = press & ((state == IDLE) | ((state == OVER) & (lock == 16'd0)));
    assign gap_load = 16'(GAP_MIN) + {10'd0, lfsr[5:0]};

    // BCD +1 with digit-wise carry; saturation is handled by the caller.
    always_comb begin
        score_inc = score;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (score[i*4 +: 4] == 4'd9) begin
                    score_inc[i*4 +: 4] = 4'd0;
                end else begin
                    score_inc[i*4 +: 4] = score[i*4 +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // Free-running LFSR (taps 16,14,13,11) and the button edge register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr  <= 16'hACE1;
            btn_q <= 1'b1;
        end else begin
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            btn_q <= btn_jump;
        end
    end

    // Game state machine with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            game_status <= 1'b0;
            game_over   <= 1'b0;
            score       <= 16'h0000;
            hi_score    <= 16'h0000;
            speed       <= SPD_INIT;
            spawn       <= 1'b0;
            pcnt        <= 16'd0;
            gap         <= 16'd0;
            lock        <= 16'd0;
        end else begin
            spawn <= 1'b0;
            if (start) begin
                state       <= RUN;
                game_status <= 1'b1;
                game_over   <= 1'b0;
                score       <= 16'h0000;
                speed       <= SPD_INIT;
                pcnt        <= 16'd0;
                gap         <= gap_load;
            end else begin
                case (state)
                    RUN: begin
                        if (collision) begin
                            // Collision beats a coincident tick: nothing else moves.
                            state       <= OVER;
                            game_status <= 1'b0;
                            game_over   <= 1'b1;
                            lock        <= 16'(OVER_LOCK);
                            if (score > hi_score)
                                hi_score <= score;
                        end else if (tick) begin
                            if (pcnt == PT_LAST) begin
                                pcnt <= 16'd0;
                                if (score != SCORE_TOP) begin
                                    score <= score_inc;
                                    if (score_inc[7:0] == 8'h00 && speed < SPD_MAX)
                                        speed <= speed + 4'd1;
                                end
                            end else begin
                                pcnt <= pcnt + 16'd1;
                            end
                            if (gap == 16'd0) begin
                                spawn <= 1'b1;
                                gap   <= gap_load;
                            end else begin
                                gap <= gap - 16'd1;
                            end
                        end
                    end
                    OVER: begin
                        if (tick && lock != 16'd0)
                            lock <= lock - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
